// File: rtl/fourbit_demux_pkg.sv
// Shared constants and types for the 1-to-4 nibble dispatcher.
//   NUM_CH     : number of output channels
//   DEST_W     : width of the destination field
//   dest_t     : destination channel index type
//   DATA_W_DEF : default nibble width
//   CNT_W_DEF  : default per-channel delivery counter width
package fourbit_demux_pkg;

  localparam int NUM_CH     = 4;
  localparam int DEST_W     = 2;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef logic [DEST_W-1:0] dest_t;

endpackage : fourbit_demux_pkg

// File: rtl/fourbit_demux_slot.sv
// One-entry output holding register with valid/ready handshake and a
// delivered-item counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data at the next edge (caller guarantees space)
//   load_data   : payload to capture
//   drain_ready : consumer takes the held item this cycle
//   valid       : slot is FULL
//   data        : held payload (keeps last value after a drain)
//   cnt         : number of drains, wraps modulo 2^CNT_W
module fourbit_demux_slot #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  logic drain;

  assign drain = valid & drain_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      // A load wins over a drain: a simultaneous drain+load stays FULL
      // with the new payload, so the channel streams without a bubble.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : fourbit_demux_slot

// File: rtl/fourbit_1to4demux_dispatch.sv
// Nibble dispatcher: routes one valid/ready nibble stream to one of four
// output channels selected by in_dest; each channel has a one-entry slot.
//   in_valid/in_ready/in_dest/in_data : producer side
//   in_bcast  : broadcast request (only honoured with FOURBIT_DEMUX_BCAST_EN)
//   out_valid/out_ready/out_data      : per-channel consumer side,
//               channel k at out_data[k*DATA_W +: DATA_W]
//   dlv_cnt   : per-channel delivered count at [k*CNT_W +: CNT_W]
// Build option: define FOURBIT_DEMUX_BCAST_EN to enable all-or-nothing
// broadcast into every slot.
module fourbit_1to4demux_dispatch
  import fourbit_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  dest_t                    in_dest,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  dlv_cnt
);

  logic              bcast;
  logic              accept;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] load;

`ifdef FOURBIT_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  logic unused_bcast;
  assign bcast        = 1'b0;
  assign unused_bcast = in_bcast;
`endif

  // A slot can take a nibble if it is empty or being drained this cycle.
  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  // NOTE: every output of this block gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    load     = '0;
    if (rst_n) begin
      in_ready = bcast ? (&slot_free) : slot_free[in_dest];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept & (bcast | (in_dest == dest_t'(k)));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    fourbit_demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[k*DATA_W +: DATA_W]),
      .cnt         (dlv_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule : fourbit_1to4demux_dispatch

// File: tb/tb_fourbit_1to4demux_dispatch.sv
// Self-checking bench for fourbit_1to4demux_dispatch: a table of directed
// single-cycle vectors plus hand-written multi-cycle sequences (reset,
// mid-operation reset, counter wrap, optional broadcast).
module tb_fourbit_1to4demux_dispatch;
  import fourbit_demux_pkg::*;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  dest_t       in_dest;
  logic [3:0]  in_data;
  logic        in_bcast;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] dlv_cnt;

  int tests = 0;
  int fails = 0;

  fourbit_1to4demux_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dlv_cnt   (dlv_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] dest;
    logic [3:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [15:0] exp_od;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge: drive, check ready, clock,
  // then check registered outputs one time unit after the edge.
  task automatic step(input vec_t t, input string name);
    in_valid  = t.v;
    in_dest   = t.dest;
    in_data   = t.data;
    out_ready = t.ordy;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
    @(posedge clk);
    #1;
    check({name, " out_valid"}, 32'(out_valid), 32'(t.exp_ov));
    check({name, " out_data"}, 32'(out_data), 32'(t.exp_od));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Producer protocol monitor: a stalled nibble must stay unchanged while
  // in_valid remains high.
  logic       stall_q = 1'b0;
  logic [1:0] held_dest;
  logic [3:0] held_data;
  always @(negedge clk) begin
    if (stall_q && rst_n && in_valid) begin
      check("producer held dest", 32'(in_dest), 32'(held_dest));
      check("producer held data", 32'(in_data), 32'(held_data));
    end
    stall_q   = rst_n & in_valid & ~in_ready;
    held_dest = in_dest;
    held_data = in_data;
  end

  initial begin
    //          v     dest  data   ordy     rdy   ov       od
    vecs[0]  = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
    vecs[1]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0110, 16'h0A30};
    vecs[2]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b0, 4'b0110, 16'h0A30};
    vecs[3]  = '{1'b1, 2'd1, 4'h5, 4'b0010, 1'b1, 4'b0110, 16'h0A50};
    vecs[4]  = '{1'b0, 2'd1, 4'h5, 4'b0010, 1'b1, 4'b0100, 16'h0A50};
    vecs[5]  = '{1'b1, 2'd0, 4'h9, 4'b0000, 1'b1, 4'b0101, 16'h0A59};
    vecs[6]  = '{1'b1, 2'd3, 4'h1, 4'b1000, 1'b1, 4'b1101, 16'h1A59};
    vecs[7]  = '{1'b1, 2'd3, 4'h2, 4'b1000, 1'b1, 4'b1101, 16'h2A59};
    vecs[8]  = '{1'b1, 2'd3, 4'h3, 4'b1000, 1'b1, 4'b1101, 16'h3A59};
    vecs[9]  = '{1'b1, 2'd3, 4'h4, 4'b1000, 1'b1, 4'b1101, 16'h4A59};
    vecs[10] = '{1'b0, 2'd3, 4'h4, 4'b1000, 1'b1, 4'b0101, 16'h4A59};
    vecs[11] = '{1'b0, 2'd0, 4'h4, 4'b0000, 1'b0, 4'b0101, 16'h4A59};

    // Reset held with a nibble offered: nothing accepted, all cleared.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_dest   = 2'd0;
    in_data   = 4'hF;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    #2;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset dlv_cnt", dlv_cnt, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: first load, back-pressure, no-bubble replace, independence.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
      if (i == 4) check("ch1 count after two drains", 32'(dlv_cnt[15:8]), 32'd2);
    end
    check("counts after table", dlv_cnt, 32'h0400_0200);

    // Fill remaining slots, then pulse reset between edges.
    step('{1'b1, 2'd1, 4'hB, 4'b0000, 1'b1, 4'b0111, 16'h4AB9}, "fill ch1");
    step('{1'b1, 2'd3, 4'hC, 4'b0000, 1'b1, 4'b1111, 16'hCAB9}, "fill ch3");
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", 32'(out_data), 32'd0);
    check("mid reset dlv_cnt", dlv_cnt, 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step('{1'b1, 2'd0, 4'h6, 4'b0000, 1'b1, 4'b0001, 16'h0006}, "post reset");

    // Counter wrap: 256 drains of ch0 with a continuous stream.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      in_valid  = 1'b1;
      in_dest   = 2'd0;
      in_data   = 4'(i);
      out_ready = 4'b0001;
      @(posedge clk);
      #1;
    end
    check("wrap count at 255", dlv_cnt, 32'h0000_00FF);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wrap count to 0", dlv_cnt, 32'd0);
    check("wrap out_valid", 32'(out_valid), 32'd0);
    check("wrap held data", 32'(out_data), 32'h0000_000F);

`ifdef FOURBIT_DEMUX_BCAST_EN
    // Broadcast is all-or-nothing: blocked by stalled ch3, then loads all.
    do_reset();
    step('{1'b1, 2'd3, 4'h1, 4'b0000, 1'b1, 4'b1000, 16'h1000}, "bcast fill ch3");
    in_bcast = 1'b1;
    step('{1'b1, 2'd0, 4'h7, 4'b0000, 1'b0, 4'b1000, 16'h1000}, "bcast blocked");
    step('{1'b1, 2'd0, 4'h7, 4'b1000, 1'b1, 4'b1111, 16'h7777}, "bcast load");
    in_bcast = 1'b0;
    in_valid = 1'b0;
    check("bcast counts", dlv_cnt, 32'h0100_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fourbit_1to4demux_dispatch

// File: doc/fourbit_1to4demux_dispatch.md
Name: fourbit_1to4demux_dispatch

Overview:
- Sequential counterpart of the 4-bit 4:1 select mux: takes one 4-bit nibble stream and distributes each nibble to one of four output channels, chosen by a 2-bit destination field.
- Every output channel has a one-entry holding register with valid/ready handshake.
- Sits between a single nibble producer and four independent consumers. Per-channel delivery counters support debug and verification.

Parameters:
- DATA_W, 4: nibble width; the channel data registers use this width.
- CNT_W, 8: width of each per-channel delivered-nibble counter.

Ports:
- clk  in  1  single clock; all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer presents a nibble.
- in_ready  out  1  dispatcher accepts this cycle.
- in_dest  in  2  destination channel 0..3; 2'b00 selects ch0 … 2'b11 selects ch3.
- in_data  in  DATA_W  nibble payload.
- in_bcast  in  1  broadcast request; used only with the optional feature.
- out_valid  out  4  bit k: channel k holds a nibble.
- out_ready  in  4  bit k: consumer k takes the nibble.
- out_data  out  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- dlv_cnt  out  4*CNT_W  channel k delivered count at [k*CNT_W +: CNT_W].

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - out_valid=0, out_data=0, dlv_cnt=0.
  - in_ready is combinational and stays low while rst_n=0.
- Slot k state machine has two states, EMPTY and FULL.
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain (out_valid[k] & out_ready[k]) with no load.
  - FULL -> FULL on a simultaneous drain and load: new data replaces old in the same edge, no bubble.
- Ready rule (non-broadcast): in_ready = ~out_valid[in_dest] | out_ready[in_dest].
  - Combinational from out_ready, so a full slot draining this cycle accepts a new nibble.
  - in_ready depends on in_dest but never on in_valid.
- Accept = in_valid & in_ready.
  - On accept, slot in_dest loads in_data at the next edge.
  - Latency: out_valid[k] rises 1 cycle after accept.
- Slot independence:
  - Traffic to other slots does not disturb a slot.
  - A full, stalled slot blocks only nibbles addressed to it (head-of-line blocking at the input is accepted).
- out_data[k] holds its value while FULL and not drained.
  - After drain the value is don't-care, but the RTL holds the last value.
- dlv_cnt[k] increments by 1 on each drain of slot k.
  - Wraps modulo 2^CNT_W (255 -> 0 at default) with no sticky flag.
- Producer rules:
  - The producer may change in_dest/in_data only after accept or while in_valid=0.
  - The dispatcher does not check this; the bench asserts it.
- Reset mid-operation: pending nibbles in slots are discarded, counters cleared, no output glitch beyond the async clear.

Optional Feature:
- Macro FOURBIT_DEMUX_BCAST_EN.
- Defined:
  - in_bcast=1 copies in_data into all four slots at once, ignoring in_dest.
  - in_ready = AND over k of (~out_valid[k] | out_ready[k]): all-or-nothing, never a partial broadcast.
  - Each slot's dlv_cnt counts its own drain.
- Undefined:
  - in_bcast is ignored (tied off internally, lint waiver); ready and load logic are exactly the non-broadcast rules.

Decomposition:
- Package fourbit_demux_pkg holds:
  - NUM_CH=4 and DEST_W=2 constants.
  - A dest_t typedef (logic[1:0]).
  - Default DATA_W and CNT_W localparams.
- Sub-module fourbit_demux_slot:
  - One-entry register with load/drain handshake and its own CNT_W counter.
  - Instantiated four times via generate.
- Top level holds only destination decode, the ready mux and the broadcast AND.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=4'b0000, all dlv_cnt=0. Release, send dest=2 data=4'hA -> next cycle out_valid=4'b0100, ch2 data=4'hA.
- Back-pressure: out_ready=0, send dest=1 data=3, then dest=1 data=5 -> second stalls (in_ready=0). Raise out_ready[1] -> 3 is delivered and 5 loads the same edge, no bubble. dlv_cnt ch1=2 after both drain.
- Independence: ch0 full and stalled, stream dest=3 nibbles 1..4 with out_ready[3]=1 -> all four accepted on consecutive cycles, ch0 data unchanged.
- Counter wrap: 256 deliveries to ch0 with CNT_W=8 -> dlv_cnt ch0 reads 0, others 0.
- Mid-operation reset: all slots full, pulse rst_n low between edges -> out_valid clears asynchronously, counters 0, first post-reset nibble delivered normally.
- With FOURBIT_DEMUX_BCAST_EN: ch3 full and stalled, in_bcast=1 data=4'h7 -> in_ready=0, no slot loads. Drain ch3 -> all four slots load 7 at once, out_valid=4'b1111.
